// File: rtl/missile_pkg.sv
// Shared types and constants for the player-missile bank.
// Slot and acknowledge state encodings, coordinate type, default fire keycode.
package missile_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        FLYING = 1'b1
    } slot_state_t;

    typedef enum logic [1:0] {
        HIT_OFF = 2'd0,
        HIT_ON  = 2'd1,
        TRANS   = 2'd2
    } hit_ack_t;

    typedef logic [9:0] coord_t;

    localparam logic [7:0] FIRE_KEY_SPACE = 8'h2c;

endpackage

// File: rtl/missile_slot.sv
// One missile slot: IDLE/FLYING state, position registers and a 2-frame hit acknowledge.
// Latency: all outputs registered, one frame after hit/launch; no backpressure.
module missile_slot
    import missile_pkg::*;
#(
    parameter int Y_STEP = 6,
    parameter int Y_MIN  = 0,
    parameter int Y_MAX  = 287
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       hit,
    input  logic       launch,
    input  logic [9:0] start_x,
    input  logic [9:0] start_y,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       reset_hit
);

    slot_state_t state, state_nxt;
    hit_ack_t    ack, ack_nxt;
    coord_t      x_nxt, y_nxt;
    logic        retire;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            ack   <= HIT_OFF;
            x     <= '0;
            y     <= '0;
        end else begin
            state <= state_nxt;
            ack   <= ack_nxt;
            x     <= x_nxt;
            y     <= y_nxt;
        end
    end

    // Retire before the step would cross the top edge, so y never wraps.
    assign retire = (state == FLYING) &&
                    ((int'(y) < Y_MIN + Y_STEP) || (int'(y) >= Y_MAX));

    always_comb begin
        state_nxt = state;
        x_nxt     = start_x;
        y_nxt     = start_y;
        if (hit || retire) begin
            state_nxt = IDLE;
        end else if (state == IDLE && launch) begin
            state_nxt = FLYING;
        end else if (state == FLYING) begin
            x_nxt = x;
            y_nxt = y - coord_t'(Y_STEP);
        end
    end

    always_comb begin
        ack_nxt = ack;
        case (ack)
            HIT_OFF: if (hit) ack_nxt = HIT_ON;
            HIT_ON:  ack_nxt = TRANS;
            TRANS:   ack_nxt = HIT_OFF;
            default: ack_nxt = HIT_OFF;
        endcase
    end

    always_comb begin
        active    = (state == FLYING);
        reset_hit = (ack != HIT_OFF);
    end

endmodule

// File: rtl/missile_bank.sv
// Multi-slot missile launcher: fire decode, launch cooldown, lowest-free-slot select.
// Latency: slot outputs registered one frame; active_count combinational; no backpressure.
module missile_bank
    import missile_pkg::*;
#(
    parameter int         NUM_MISSILES = 4,
    parameter int         Y_STEP       = 6,
    parameter int         Y_MIN        = 0,
    parameter int         Y_MAX        = 287,
    parameter int         X_OFFSET     = 1,
    parameter int         Y_OFFSET     = 3,
    parameter int         COOLDOWN     = 8,
    parameter logic [7:0] FIRE_KEY     = FIRE_KEY_SPACE
) (
    input  logic                         frame_clk,
    input  logic                         Reset,
    input  logic [15:0]                  keycode,
    input  logic [9:0]                   ship_x,
    input  logic [9:0]                   ship_y,
    input  logic [NUM_MISSILES-1:0]      hit,
    output logic [10*NUM_MISSILES-1:0]   missile_x,
    output logic [10*NUM_MISSILES-1:0]   missile_y,
    output logic [NUM_MISSILES-1:0]      missile_active,
    output logic [NUM_MISSILES-1:0]      reset_hit,
    output logic [3:0]                   active_count
);

    localparam int CW = $clog2(COOLDOWN + 1);

    logic [CW-1:0]           cooldown;
    logic                    fire;
    logic                    launch_go;
    logic [NUM_MISSILES-1:0] eligible;
    logic [NUM_MISSILES-1:0] sel;
    logic [NUM_MISSILES-1:0] launch;
    coord_t                  start_x, start_y;

    assign fire    = (keycode[7:0] == FIRE_KEY) || (keycode[15:8] == FIRE_KEY);
    assign start_x = ship_x - coord_t'(X_OFFSET);
    assign start_y = ship_y - coord_t'(Y_OFFSET);

    // A slot being hit this frame is freed only at the edge, so it cannot also launch.
    assign eligible  = ~missile_active & ~hit;
    assign launch_go = fire && (cooldown == '0) && (|eligible);
    assign launch    = launch_go ? sel : '0;

    always_comb begin
        sel = '0;
        for (int i = NUM_MISSILES - 1; i >= 0; i--) begin
            if (eligible[i]) sel = NUM_MISSILES'(1) << i;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            cooldown <= '0;
        end else if (launch_go) begin
            cooldown <= CW'(COOLDOWN);
        end else if (cooldown != '0) begin
            cooldown <= cooldown - 1'b1;
        end
    end

    always_comb begin
        active_count = '0;
        for (int i = 0; i < NUM_MISSILES; i++) begin
            active_count = active_count + 4'(missile_active[i]);
        end
    end

    for (genvar i = 0; i < NUM_MISSILES; i++) begin : g_slot
        missile_slot #(
            .Y_STEP (Y_STEP),
            .Y_MIN  (Y_MIN),
            .Y_MAX  (Y_MAX)
        ) u_slot (
            .frame_clk (frame_clk),
            .Reset     (Reset),
            .hit       (hit[i]),
            .launch    (launch[i]),
            .start_x   (start_x),
            .start_y   (start_y),
            .x         (missile_x[10*i +: 10]),
            .y         (missile_y[10*i +: 10]),
            .active    (missile_active[i]),
            .reset_hit (reset_hit[i])
        );
    end

endmodule

// File: tb/tb_missile_bank.sv
// Bench for missile_bank: directed scenarios plus random frames against a behavioural model.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each frame.
module tb_missile_bank;

    localparam int N = 4;

    logic          frame_clk = 1'b0;
    logic          Reset     = 1'b1;
    logic [15:0]   keycode   = '0;
    logic [9:0]    ship_x    = '0;
    logic [9:0]    ship_y    = '0;
    logic [N-1:0]  hit       = '0;
    logic [10*N-1:0] missile_x, missile_y;
    logic [N-1:0]  missile_active, reset_hit;
    logic [3:0]    active_count;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit m_fly [N];
    int m_x   [N];
    int m_y   [N];
    int m_ack [N];
    int m_cd;

    missile_bank u_dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .keycode        (keycode),
        .ship_x         (ship_x),
        .ship_y         (ship_y),
        .hit            (hit),
        .missile_x      (missile_x),
        .missile_y      (missile_y),
        .missile_active (missile_active),
        .reset_hit      (reset_hit),
        .active_count   (active_count)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_fly[i] = 0; m_x[i] = 0; m_y[i] = 0; m_ack[i] = 0;
        end
        m_cd = 0;
    endtask

    // Apply one frame's worth of inputs and advance both DUT and model by one edge.
    task automatic frame(input logic [15:0] k, input logic [N-1:0] h);
        bit fire;
        int sx, sy, chosen;
        keycode = k;
        hit     = h;
        fire    = (k[7:0] == 8'h2c) || (k[15:8] == 8'h2c);
        sx      = (int'(ship_x) - 1) & 1023;
        sy      = (int'(ship_y) - 3) & 1023;
        chosen  = -1;
        if (fire && m_cd == 0) begin
            for (int i = 0; i < N; i++)
                if (chosen < 0 && !m_fly[i] && !h[i]) chosen = i;
        end
        @(posedge frame_clk);
        if (chosen >= 0) m_cd = 8;
        else if (m_cd > 0) m_cd = m_cd - 1;
        for (int i = 0; i < N; i++) begin
            if (m_ack[i] == 0 && h[i]) m_ack[i] = 2;
            else if (m_ack[i] > 0) m_ack[i] = m_ack[i] - 1;
            if (h[i] || (m_fly[i] && (m_y[i] < 6 || m_y[i] >= 287))) begin
                m_fly[i] = 0; m_x[i] = sx; m_y[i] = sy;
            end else if (!m_fly[i] && i == chosen) begin
                m_fly[i] = 1; m_x[i] = sx; m_y[i] = sy;
            end else if (m_fly[i]) begin
                m_y[i] = m_y[i] - 6;
            end else begin
                m_x[i] = sx; m_y[i] = sy;
            end
        end
        @(negedge frame_clk);
    endtask

    task automatic do_reset();
        @(negedge frame_clk);
        Reset = 1'b1; keycode = '0; hit = '0;
        model_reset();
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge frame_clk);
        Reset = 1'b1; keycode = 16'h2c2c; hit = '1;
        model_reset();
        #1;
        total++; if (missile_x !== '0) begin bad++; $display("FAIL reset_x got=%h want=0", missile_x); end
        total++; if (missile_y !== '0) begin bad++; $display("FAIL reset_y got=%h want=0", missile_y); end
        total++; if (missile_active !== '0) begin bad++; $display("FAIL reset_active got=%b want=0", missile_active); end
        total++; if (reset_hit !== '0) begin bad++; $display("FAIL reset_hit got=%b want=0", reset_hit); end
        total++; if (active_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", active_count); end
        @(negedge frame_clk);
        Reset = 1'b0; keycode = '0; hit = '0;
    endtask

    task automatic test_single_shot();
        do_reset();
        ship_x = 10'd320; ship_y = 10'd240;
        frame(16'h002c, '0);
        total++; if (missile_active !== 4'b0001) begin bad++; $display("FAIL shot_active got=%b want=0001", missile_active); end
        total++; if (missile_x[9:0] !== 10'd319 || missile_y[9:0] !== 10'd237) begin
            bad++; $display("FAIL shot_pos got=(%0d,%0d) want=(319,237)", missile_x[9:0], missile_y[9:0]); end
        frame(16'h0000, '0);
        total++; if (missile_y[9:0] !== 10'd231) begin bad++; $display("FAIL shot_step got=%0d want=231", missile_y[9:0]); end
        // Releasing the key must not clear the cooldown: the next launch is still frame 9.
        for (int f = 2; f <= 9; f++) begin
            frame(16'h2c00, '0);
            if (f == 8) begin
                total++; if (missile_active[1] !== 1'b0) begin bad++; $display("FAIL shot_cooldown got=%b want=0", missile_active[1]); end
            end
        end
        total++; if (missile_active !== 4'b0011) begin bad++; $display("FAIL shot_relaunch got=%b want=0011", missile_active); end
    endtask

    task automatic test_auto_fire();
        logic [N-1:0] prev;
        do_reset();
        ship_x = 10'd320; ship_y = 10'd240;
        for (int f = 0; f < 40; f++) begin
            prev = missile_active;
            frame(16'h002c, '0);
            if (f % 9 == 0 && f < 36) begin
                total++; if ((missile_active & ~prev) !== (N'(1) << (f / 9))) begin
                    bad++; $display("FAIL auto_launch f=%0d got=%b want=%b", f, missile_active & ~prev, N'(1) << (f / 9)); end
            end else begin
                total++; if ((missile_active & ~prev) !== '0) begin
                    bad++; $display("FAIL auto_nolaunch f=%0d got=%b want=0", f, missile_active & ~prev); end
            end
        end
        total++; if (active_count !== 4'd4) begin bad++; $display("FAIL auto_count got=%0d want=4", active_count); end
    endtask

    task automatic test_hit_ack();
        do_reset();
        ship_x = 10'd320; ship_y = 10'd240;
        for (int f = 0; f < 10; f++) frame(16'h002c, '0);
        frame(16'h0000, 4'b0010);
        total++; if (missile_active[1] !== 1'b0 || missile_x[19:10] !== 10'd319 || missile_y[19:10] !== 10'd237) begin
            bad++; $display("FAIL hit_clear got=%b(%0d,%0d) want=0(319,237)", missile_active[1], missile_x[19:10], missile_y[19:10]); end
        total++; if (reset_hit !== 4'b0010) begin bad++; $display("FAIL hit_ack1 got=%b want=0010", reset_hit); end
        frame(16'h0000, 4'b0010);
        total++; if (reset_hit !== 4'b0010) begin bad++; $display("FAIL hit_ack2 got=%b want=0010", reset_hit); end
        frame(16'h0000, '0);
        total++; if (reset_hit !== 4'b0000) begin bad++; $display("FAIL hit_ack3 got=%b want=0000", reset_hit); end
    endtask

    task automatic test_retire();
        do_reset();
        ship_x = 10'd100; ship_y = 10'd14;
        frame(16'h002c, '0);
        frame(16'h0000, '0);
        total++; if (missile_active[0] !== 1'b1 || missile_y[9:0] !== 10'd5) begin
            bad++; $display("FAIL retire_pre got=%b/%0d want=1/5", missile_active[0], missile_y[9:0]); end
        frame(16'h0000, '0);
        total++; if (missile_active[0] !== 1'b0 || missile_y[9:0] !== 10'd11) begin
            bad++; $display("FAIL retire_post got=%b/%0d want=0/11", missile_active[0], missile_y[9:0]); end
    endtask

    task automatic test_multi_hit();
        do_reset();
        ship_x = 10'd320; ship_y = 10'd240;
        for (int f = 0; f < 19; f++) frame(16'h002c, '0);
        frame(16'h0000, 4'b0010);
        for (int f = 0; f < 9; f++) frame(16'h0000, '0);
        total++; if (missile_active !== 4'b0101) begin bad++; $display("FAIL multi_setup got=%b want=0101", missile_active); end
        frame(16'h2c00, 4'b0101);
        total++; if (missile_active !== 4'b0010) begin bad++; $display("FAIL multi_launch got=%b want=0010", missile_active); end
        total++; if (reset_hit !== 4'b0101) begin bad++; $display("FAIL multi_ack1 got=%b want=0101", reset_hit); end
        frame(16'h0000, '0);
        total++; if (reset_hit !== 4'b0101) begin bad++; $display("FAIL multi_ack2 got=%b want=0101", reset_hit); end
        frame(16'h0000, '0);
        total++; if (reset_hit !== 4'b0000) begin bad++; $display("FAIL multi_ack3 got=%b want=0000", reset_hit); end
    endtask

    task automatic test_async_reset();
        do_reset();
        ship_x = 10'd320; ship_y = 10'd240;
        for (int f = 0; f < 19; f++) frame(16'h002c, '0);
        total++; if (active_count !== 4'd3) begin bad++; $display("FAIL async_setup got=%0d want=3", active_count); end
        #2 Reset = 1'b1;
        model_reset();
        #1;
        total++; if (missile_active !== '0 || missile_x !== '0 || missile_y !== '0 || reset_hit !== '0 || active_count !== 4'd0) begin
            bad++; $display("FAIL async_clear got=%b/%h/%h/%b/%0d want=all 0", missile_active, missile_x, missile_y, reset_hit, active_count); end
        @(negedge frame_clk);
        Reset = 1'b0;
        frame(16'h002c, '0);
        total++; if (missile_active !== 4'b0001) begin bad++; $display("FAIL async_relaunch got=%b want=0001", missile_active); end
    endtask

    task automatic test_random();
        logic [15:0] k;
        logic [N-1:0] h;
        do_reset();
        for (int f = 0; f < 600; f++) begin
            if ($urandom_range(0, 15) == 0) begin
                ship_x = 10'($urandom_range(0, 1023));
                ship_y = 10'($urandom_range(0, 300));
            end
            case ($urandom_range(0, 3))
                0: k = 16'h002c;
                1: k = 16'h2c11;
                2: k = 16'h1234;
                default: k = 16'h0000;
            endcase
            for (int i = 0; i < N; i++) h[i] = ($urandom_range(0, 9) == 0);
            frame(k, h);
            for (int i = 0; i < N; i++) begin
                total++;
                if (missile_active[i] !== m_fly[i] || missile_x[10*i +: 10] !== 10'(m_x[i]) ||
                    missile_y[10*i +: 10] !== 10'(m_y[i]) || reset_hit[i] !== (m_ack[i] > 0)) begin
                    bad++;
                    $display("FAIL rand_slot f=%0d i=%0d got=%b(%0d,%0d)ack%b want=%b(%0d,%0d)ack%0d",
                             f, i, missile_active[i], missile_x[10*i +: 10], missile_y[10*i +: 10], reset_hit[i],
                             m_fly[i], m_x[i], m_y[i], m_ack[i]);
                end
            end
            total++;
            if (int'(active_count) != int'(m_fly[0]) + int'(m_fly[1]) + int'(m_fly[2]) + int'(m_fly[3])) begin
                bad++; $display("FAIL rand_count f=%0d got=%0d", f, active_count);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_shot();
        test_auto_fire();
        test_hit_ack();
        test_retire();
        test_multi_hit();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
